// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The buffered entry pairs each instruction word with the PC it was fetched from.
package fetch_stage_pkg;

    localparam int CORE_XLEN = 32;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [31:0]          instr;
    } fetch_entry_t;

    function automatic logic [CORE_XLEN-1:0] align_word(input logic [CORE_XLEN-1:0] addr);
        return {addr[CORE_XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction memory request/response, redirect from
// execute, and the instruction handshake toward decode.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid_o;
    logic            imem_req_ready_i;
    logic [XLEN-1:0] imem_req_addr_o;
    logic            imem_rsp_valid_i;
    logic [31:0]     imem_rsp_data_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [31:0]     instruction_o;
    logic [XLEN-1:0] pc_o;

    modport master (
        output imem_req_valid_o, imem_req_addr_o, instr_valid_o, instruction_o, pc_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  redirect_i, redirect_pc_i, instr_ready_i
    );

    modport slave (
        input  imem_req_valid_o, imem_req_addr_o, instr_valid_o, instruction_o, pc_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output redirect_i, redirect_pc_i, instr_ready_i
    );
endinterface

// File: rtl/fetch_stage_fifo.sv
// Instruction buffer between memory responses and decode. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a separate counter.
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           flush,
    input  fetch_entry_t                   push_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output fetch_entry_t                   head
);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem_r [DEPTH];
    logic [AW:0]  wr_ptr_r;
    logic [AW:0]  rd_ptr_r;
    logic         push_ok_s;
    logic         pop_ok_s;

    assign count     = wr_ptr_r - rd_ptr_r;
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update; flush discards all buffered entries at the edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues word fetches under a credit limit, tracks
// in-order responses, buffers them with their PCs and hands them to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int              XLEN       = CORE_XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}},
    parameter int              FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.master  bus
);
    localparam int            CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(FIFO_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_r;
    logic [XLEN-1:0] rsp_pc_r;
    logic [XLEN-1:0] last_pc_r;
    logic [CW-1:0]   outstanding_r;
    logic [CW-1:0]   drop_r;

    logic [CW-1:0]   fifo_count_s;
    logic [CW:0]     credit_sum_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    fetch_entry_t    fifo_head_s;
    fetch_entry_t    push_entry_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            push_s;
    logic            pop_s;
    logic            instr_valid_s;
    logic [31:0]     instruction_s;
    logic [XLEN-1:0] pc_s;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .flush     (bus.redirect_i),
        .push_data (push_entry_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s),
        .head      (fifo_head_s)
    );

    // Credit, handshake and decode-side presentation logic.
    always_comb begin
        credit_sum_s  = {1'b0, outstanding_r} + {1'b0, fifo_count_s};
        req_valid_s   = 1'b0;
        push_s        = 1'b0;
        instr_valid_s = 1'b0;
        instruction_s = INSTR_NOP;
        pc_s          = last_pc_r;
        push_entry_s  = '{pc: rsp_pc_r, instr: bus.imem_rsp_data_i};
        // Every in-flight request has a reserved slot, so responses never overflow.
        if (!rst && !bus.redirect_i && (credit_sum_s < DEPTH_W)) begin
            req_valid_s = 1'b1;
        end else begin
            req_valid_s = 1'b0;
        end
        if (bus.imem_rsp_valid_i && (drop_r == CW'(0)) && !bus.redirect_i && !fifo_full_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (fifo_empty_s) begin
            instruction_s = INSTR_NOP;
            pc_s          = last_pc_r;
        end else begin
            instruction_s = fifo_head_s.instr;
            pc_s          = fifo_head_s.pc;
        end
        instr_valid_s = !rst && !fifo_empty_s && !bus.redirect_i;
    end

    assign req_fire_s = req_valid_s && bus.imem_req_ready_i;
    assign pop_s      = instr_valid_s && bus.instr_ready_i;

    assign bus.imem_req_valid_o = req_valid_s;
    assign bus.imem_req_addr_o  = fetch_pc_r;
    assign bus.instr_valid_o    = instr_valid_s;
    assign bus.instruction_o    = instruction_s;
    assign bus.pc_o             = pc_s;

    // PC, in-flight and drop bookkeeping; redirect overrides normal progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            last_pc_r     <= RESET_PC;
            outstanding_r <= CW'(0);
            drop_r        <= CW'(0);
        end else begin
            last_pc_r <= pc_s;
            case ({req_fire_s, bus.imem_rsp_valid_i})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            if (bus.redirect_i) begin
                fetch_pc_r <= align_word(bus.redirect_pc_i);
                rsp_pc_r   <= align_word(bus.redirect_pc_i);
                // A response arriving alongside the redirect is already stale.
                drop_r     <= outstanding_r - (bus.imem_rsp_valid_i ? CW'(1) : CW'(0));
            end else begin
                if (req_fire_s) fetch_pc_r <= fetch_pc_r + PC_STEP;
                if (push_s)     rsp_pc_r   <= rsp_pc_r + PC_STEP;
                if (bus.imem_rsp_valid_i && (drop_r != CW'(0))) drop_r <= drop_r - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage with a latency-modelling
// instruction memory and an in-order scoreboard of expected PC/instruction pairs.
module tb_fetch_stage;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] addr; int due; bit stale; } mem_item_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

    logic clk;
    logic rst;
    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC), .FIFO_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_item_t   mem_q[$];
    exp_t        exp_q[$];
    int          checks;
    int          errors;
    int          cyc;
    int          last_due;
    int          lat_min;
    int          lat_max;
    int          obs_req;
    bit          rand_mode;
    bit          req_rdy_cfg;
    bit          dec_rdy_cfg;
    logic [31:0] fetch_model;
    logic [31:0] last_pc;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {~addr[15:0], addr[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, sample 1ns later, update models.
    task automatic step(input bit rdir, input logic [31:0] rpc);
        bit          deliver;
        bit          exp_req;
        bit          exp_iv;
        bit          rr;
        bit          dr;
        int          due;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
        mem_item_t   it;
        rr = rand_mode ? ($urandom_range(0, 3) != 0) : req_rdy_cfg;
        dr = rand_mode ? ($urandom_range(0, 2) != 0) : dec_rdy_cfg;
        deliver = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        bus.imem_rsp_valid_i = deliver;
        bus.imem_rsp_data_i  = deliver ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        bus.redirect_i       = rdir;
        bus.redirect_pc_i    = rpc;
        bus.imem_req_ready_i = rr;
        bus.instr_ready_i    = dr;
        #1;
        exp_req = !rdir && ((mem_q.size() + exp_q.size()) < 4);
        check("req_valid", {31'd0, bus.imem_req_valid_o}, {31'd0, exp_req});
        if (exp_req) check("req_addr", bus.imem_req_addr_o, fetch_model);
        if (bus.imem_req_valid_o && rr) obs_req++;
        exp_iv    = (exp_q.size() > 0) && !rdir;
        exp_instr = (exp_q.size() > 0) ? exp_q[0].instr : NOP;
        exp_pc    = (exp_q.size() > 0) ? exp_q[0].pc : last_pc;
        check("instr_valid", {31'd0, bus.instr_valid_o}, {31'd0, exp_iv});
        check("instruction", bus.instruction_o, exp_instr);
        check("pc", bus.pc_o, exp_pc);
        last_pc = exp_pc;
        if (exp_iv && dr) void'(exp_q.pop_front());
        if (deliver) begin
            it = mem_q.pop_front();
            if (!it.stale && !rdir) exp_q.push_back('{it.addr, mem_word(it.addr)});
        end
        if (rdir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            fetch_model = {rpc[31:2], 2'b00};
        end else if (exp_req && rr) begin
            due = cyc + $urandom_range(lat_min, lat_max);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{fetch_model, due, 1'b0});
            fetch_model = fetch_model + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        int  occ;
        int  base;
        bit  found;
        checks = 0; errors = 0; cyc = 0; last_due = -1; obs_req = 0;
        lat_min = 1; lat_max = 1; rand_mode = 1'b0;
        req_rdy_cfg = 1'b1; dec_rdy_cfg = 1'b1;
        fetch_model = RESET_PC; last_pc = RESET_PC;
        rst = 1'b1;
        bus.imem_req_ready_i = 1'b0; bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i = 32'h0; bus.redirect_i = 1'b0;
        bus.redirect_pc_i = 32'h0; bus.instr_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Streaming, 1-cycle latency, everything ready.
        repeat (12) step(1'b0, 32'h0);

        // Decode stall: requests stop once credits are exhausted.
        dec_rdy_cfg = 1'b0;
        occ  = mem_q.size() + exp_q.size();
        base = obs_req;
        repeat (10) step(1'b0, 32'h0);
        check("stall_req_count", 32'(obs_req - base), 32'(4 - occ));
        dec_rdy_cfg = 1'b1;
        repeat (10) step(1'b0, 32'h0);

        // Redirect with requests in flight at 3-cycle latency.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_q.size() >= 2) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        check("wait_inflight", {31'd0, found}, 32'd1);
        step(1'b1, 32'h0000_0100);
        repeat (12) step(1'b0, 32'h0);

        // Misaligned redirect landing on a response arrival.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) found = 1'b1;
            else step(1'b0, 32'h0);
        end
        check("wait_rsp_coincide", {31'd0, found}, 32'd1);
        step(1'b1, 32'h0000_0203);
        repeat (12) step(1'b0, 32'h0);

        // Back-to-back redirects, then wrap past the top of the address space.
        step(1'b1, 32'h0000_0300);
        step(1'b1, 32'h0000_0404);
        repeat (10) step(1'b0, 32'h0);
        step(1'b1, 32'hFFFF_FFF8);
        repeat (12) step(1'b0, 32'h0);

        // Random readiness and latency.
        lat_min = 1; lat_max = 4; rand_mode = 1'b1;
        repeat (300) step(1'b0, 32'h0);
        rand_mode = 1'b0;

        // Fill the buffer, then reset mid-operation.
        lat_min = 1; lat_max = 1; dec_rdy_cfg = 1'b0;
        repeat (10) step(1'b0, 32'h0);
        rst = 1'b1;
        bus.imem_rsp_valid_i = 1'b0; bus.redirect_i = 1'b0;
        mem_q.delete(); exp_q.delete();
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        fetch_model = RESET_PC; last_pc = RESET_PC;
        dec_rdy_cfg = 1'b1;
        repeat (12) step(1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
